raccoon2ram_pipe: RTL and testbench
===================================

// Module: raccoon2ram_pipe
// PURPOSE
//  Raccoon ring slave to synchronous RAM port, parametrised successor of the single-cycle RAM bridge.
//  Sits in the 64-bit Raccoon ring; claims requests in one address window, drives a RAM with
//  configurable read latency and returns responses in the same ring slot. Packets it does not claim pass through.
//  Adds: RAM read latency 1..4, optional write acknowledge, optional read-only window with error response.
// PARAMETERS
//  ADDR_MASK   20'hF0000  byte-address bits compared for window match
//  ADDR_BASE   20'h10000  window base (compared under ADDR_MASK)
//  RD_LATENCY  1          cycles from CS high to RD_DATA valid (legal 1..4)
//  WR_ACK      1          1: write returns response slot; 0: write slot emptied (64'd0)
//  READ_ONLY   0          1: writes into window rejected with error response, RAM not written
// PORTS
//  CLK      in   1   clock, all state on rising edge
//  RST      in   1   asynchronous, active-high reset
//  RaccIn   in   64  ring input slot
//  RaccOut  out  64  ring output slot (registered)
//  CS       out  1   RAM select, one cycle per claimed access
//  WE       out  1   RAM write enable (valid with CS)
//  ADDR     out  20  RAM byte address {word_addr[17:0],2'b00}
//  MASK     out  4   RAM byte write mask
//  WR_DATA  out  32  RAM write data
//  RD_DATA  in   32  RAM read data, valid RD_LATENCY cycles after CS
// BEHAVIOUR
//  Slot format: [63:62] type (11=request, 10=response, 01=error response, 00=empty), [61:54] tag/src,
//   [53:50] byte mask (nonzero = write), [49:32] word address, [31:0] data.
//  Stage 0: RaccIn registered into din every cycle, no stall, no backpressure.
//  Match: din[63:62]==2'b11 && ({din[49:32],2'b00} & ADDR_MASK)==(ADDR_BASE & ADDR_MASK).
//  Classify din: NONE (no match), RD (match, mask 0), WR (match, mask!=0, READ_ONLY=0), ERR (match, mask!=0, READ_ONLY=1).
//  RAM drive from din (combinational): CS=RD|WR; WE=WR; ADDR/MASK/WR_DATA from din fields; ERR never asserts CS.
//  Delay line: RD_LATENCY registered stages carry {din, class}; every cycle advances one stage.
//  Output stage (registered into RaccOut) from last delay stage, RD_DATA sampled same cycle:
//   NONE -> packet unchanged; RD -> {2'b10, pkt[61:32], RD_DATA};
//   WR -> WR_ACK ? {2'b10, pkt[61:32], 32'd0} : 64'd0; ERR -> {2'b01, pkt[61:32], 32'd0}.
//  Latency RaccIn->RaccOut fixed = RD_LATENCY+2 for every slot type; slot order preserved.
//  Back-to-back requests each cycle sustained at full rate; RAM sees one access per cycle max.
//  Response/empty/error slots never match (type != 11) and pass through unchanged even if address in window.
//  Read-after-write to same address in consecutive cycles: RAM ordering governs; block adds no forwarding.
//  Reset: din, all delay stages, RaccOut = 64'd0; class = NONE; hence CS=0, WE=0, ADDR=0, MASK=0,
//   WR_DATA=0 during and after reset. Reset mid-flight discards in-flight slots (no response emitted).
//  RD_LATENCY outside 1..4 is a configuration error (elaboration check).
// TESTING
//  1 RD_LATENCY=2: RaccIn={2'b11,8'h5A,4'h0,18'h04000,32'h0} (byte addr 0x10000), RAM returns 32'hDEADBEEF
//    -> CS=1,WE=0,ADDR=20'h10000 one cycle; RaccOut={2'b10,8'h5A,4'h0,18'h04000,32'hDEADBEEF} 4 cycles after input.
//  2 WR_ACK=0: write mask 4'h3, data 32'h1234_5678 -> CS=1,WE=1,MASK=3,WR_DATA=0x12345678; RaccOut slot=64'd0.
//    WR_ACK=1: same -> RaccOut type 10, tag kept, data 0.
//  3 READ_ONLY=1: write in window -> CS stays 0; RaccOut={2'b01,hdr,32'd0}; read in window still returns data.
//  4 Pass-through: request at byte addr 0x20000, a 2'b10 slot and 64'd0 -> RaccOut identical, CS never set,
//    latency RD_LATENCY+2.
//  5 Stream 8 back-to-back reads addr 0..7 (RAM model data=addr*3), RD_LATENCY 1..4 -> 8 consecutive responses,
//    in order, correct data, no gaps.
//  6 Assert RST while 3 reads in flight -> RaccOut=0 and CS=0 immediately; after release only new traffic responds.

Source files
------------

// File: rtl/raccoon2ram_pipe.sv
// Raccoon ring slave bridging one address window onto a synchronous RAM with 1..4 cycle read latency.
// Every slot takes RD_LATENCY+2 cycles from RaccIn to RaccOut regardless of type, so ring order is kept.
module raccoon2ram_pipe #(
  parameter logic [19:0] ADDR_MASK  = 20'hF0000,
  parameter logic [19:0] ADDR_BASE  = 20'h10000,
  parameter int          RD_LATENCY = 1,
  parameter bit          WR_ACK     = 1'b1,
  parameter bit          READ_ONLY  = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] RaccIn,
  output logic [63:0] RaccOut,
  output logic        CS,
  output logic        WE,
  output logic [19:0] ADDR,
  output logic [3:0]  MASK,
  output logic [31:0] WR_DATA,
  input  logic [31:0] RD_DATA
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("raccoon2ram_pipe: RD_LATENCY must be 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {CL_NONE, CL_RD, CL_WR, CL_ERR} cls_e;

  logic [63:0] din;
  cls_e        din_cls;
  logic        match;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) din <= 64'd0;
    else     din <= RaccIn;
  end

  always_comb begin
    match   = (din[63:62] == 2'b11) &&
              (({din[49:32], 2'b00} & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
    din_cls = CL_NONE;
    if (match) begin
      if (din[53:50] == 4'h0) din_cls = CL_RD;
      else if (READ_ONLY)     din_cls = CL_ERR;
      else                    din_cls = CL_WR;
    end
  end

  // RAM port is driven straight from din; rejected writes never reach the RAM.
  assign CS      = (din_cls == CL_RD) || (din_cls == CL_WR);
  assign WE      = (din_cls == CL_WR);
  assign ADDR    = {din[49:32], 2'b00};
  assign MASK    = din[53:50];
  assign WR_DATA = din[31:0];

  // Delay line matches the RAM read latency so RD_DATA lines up with its slot.
  logic [RD_LATENCY-1:0][63:0] dl_pkt;
  cls_e [RD_LATENCY-1:0]       dl_cls;

  for (genvar g = 0; g < RD_LATENCY; g++) begin : g_dl
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        dl_pkt[g] <= 64'd0;
        dl_cls[g] <= CL_NONE;
      end else if (g == 0) begin
        dl_pkt[g] <= din;
        dl_cls[g] <= din_cls;
      end else begin
        dl_pkt[g] <= dl_pkt[(g == 0) ? 0 : g-1];
        dl_cls[g] <= dl_cls[(g == 0) ? 0 : g-1];
      end
    end
  end

  logic [63:0] last_pkt;
  cls_e        last_cls;
  logic [63:0] out_nxt;

  assign last_pkt = dl_pkt[RD_LATENCY-1];
  assign last_cls = dl_cls[RD_LATENCY-1];

  always_comb begin
    out_nxt = last_pkt;
    unique case (last_cls)
      CL_RD:   out_nxt = {2'b10, last_pkt[61:32], RD_DATA};
      CL_WR:   out_nxt = WR_ACK ? {2'b10, last_pkt[61:32], 32'd0} : 64'd0;
      CL_ERR:  out_nxt = {2'b01, last_pkt[61:32], 32'd0};
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) RaccOut <= 64'd0;
    else     RaccOut <= out_nxt;
  end

endmodule

// File: tb/tb_raccoon2ram_pipe.sv
// Four bridge configurations (latency 1..4, ack on/off, read-only) share one ring stream;
// each has its own RAM model, reference memory and output/RAM-access scoreboards.
module tb_raccoon2ram_pipe;

  localparam int NI = 4;

  function automatic bit wr_ack_of(int k); return (k % 2) == 0; endfunction
  function automatic bit ro_of(int k);     return k == 2;       endfunction

  typedef struct { logic [63:0] pkt; int cyc; } exp_t;
  typedef struct { logic we; logic [19:0] addr; logic [3:0] mask; logic [31:0] wd; int cyc; } ram_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [63:0] RaccIn = 64'd0;

  logic [63:0] rout [NI];
  logic        cs   [NI];
  logic        we   [NI];
  logic [19:0] addr [NI];
  logic [3:0]  mask [NI];
  logic [31:0] wd   [NI];
  logic [31:0] rd   [NI];

  exp_t        oq [NI][$];
  ram_t        rq [NI][$];
  logic [31:0] refmem [NI][256];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d: got %h want %h", name, k, cyc, act, exp);
    end
  endtask

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int LAT = k + 1;
    logic [31:0] mem [256];
    logic [31:0] rp  [LAT:1];

    raccoon2ram_pipe #(
      .RD_LATENCY(LAT), .WR_ACK(wr_ack_of(k)), .READ_ONLY(ro_of(k))
    ) u_dut (
      .CLK(CLK), .RST(RST), .RaccIn(RaccIn), .RaccOut(rout[k]),
      .CS(cs[k]), .WE(we[k]), .ADDR(addr[k]), .MASK(mask[k]),
      .WR_DATA(wd[k]), .RD_DATA(rd[k])
    );

    initial for (int i = 0; i < 256; i++) mem[i] = 32'(i * 3);

    // RAM: read data appears LAT cycles after the select cycle.
    always @(posedge CLK) begin
      for (int i = LAT; i >= 2; i--) rp[i] <= rp[i-1];
      rp[1] <= (cs[k] && !we[k]) ? mem[addr[k][9:2]] : 32'hBAD0_BAD0;
      if (cs[k] && we[k])
        for (int b = 0; b < 4; b++)
          if (mask[k][b]) mem[addr[k][9:2]][8*b +: 8] = wd[k][8*b +: 8];
    end
    assign rd[k] = rp[LAT];

    always @(negedge CLK) begin
      if (!RST) begin
        while (oq[k].size() > 0 && oq[k][0].cyc < cyc) begin
          chk("missing_out", k, 64'd0, oq[k][0].pkt);
          void'(oq[k].pop_front());
        end
        while (rq[k].size() > 0 && rq[k][0].cyc < cyc) begin
          chk("missing_cs", k, 64'd0, 64'd1);
          void'(rq[k].pop_front());
        end
        if (rout[k] != 64'd0) begin
          if (oq[k].size() == 0) chk("unexpected_out", k, rout[k], 64'd0);
          else begin
            exp_t e;
            e = oq[k].pop_front();
            chk("out_slot", k, rout[k], e.pkt);
            chk("out_latency", k, 64'(cyc), 64'(e.cyc));
          end
        end
        if (cs[k]) begin
          if (rq[k].size() == 0) chk("unexpected_cs", k, 64'd1, 64'd0);
          else begin
            ram_t r;
            r = rq[k].pop_front();
            chk("ram_access", k, {7'd0, we[k], addr[k], mask[k], wd[k]},
                {7'd0, r.we, r.addr, r.mask, r.wd});
            chk("ram_cycle", k, 64'(cyc), 64'(r.cyc));
          end
        end
      end
    end
  end

  function automatic logic [63:0] mk(logic [1:0] t, logic [7:0] tag, logic [3:0] m,
                                     logic [17:0] wa, logic [31:0] d);
    return {t, tag, m, wa, d};
  endfunction

  // Reference: the window is byte addresses 0x1xxxx; memory updated in issue order.
  task automatic predict(logic [63:0] p);
    logic [17:0] wa;
    logic [3:0]  m;
    bit          hit;
    wa  = p[49:32];
    m   = p[53:50];
    hit = (p[63:62] == 2'b11) && ((int'(wa) * 4) / 65536 == 1);
    for (int k = 0; k < NI; k++) begin
      int lat = k + 1;
      if (!hit) begin
        if (p != 64'd0) oq[k].push_back('{pkt: p, cyc: cyc + lat + 2});
      end else if (m == 4'd0) begin
        rq[k].push_back('{we: 1'b0, addr: {wa, 2'b00}, mask: m, wd: p[31:0], cyc: cyc + 1});
        oq[k].push_back('{pkt: {2'b10, p[61:32], refmem[k][wa[7:0]]}, cyc: cyc + lat + 2});
      end else if (ro_of(k)) begin
        oq[k].push_back('{pkt: {2'b01, p[61:32], 32'd0}, cyc: cyc + lat + 2});
      end else begin
        rq[k].push_back('{we: 1'b1, addr: {wa, 2'b00}, mask: m, wd: p[31:0], cyc: cyc + 1});
        for (int b = 0; b < 4; b++)
          if (m[b]) refmem[k][wa[7:0]][8*b +: 8] = p[8*b +: 8];
        if (wr_ack_of(k)) oq[k].push_back('{pkt: {2'b10, p[61:32], 32'd0}, cyc: cyc + lat + 2});
      end
    end
  endtask

  task automatic issue(logic [63:0] p);
    @(negedge CLK);
    RaccIn = p;
    predict(p);
  endtask

  function automatic logic [63:0] rand_pkt();
    int          r;
    logic [17:0] wa;
    logic [3:0]  m;
    logic [1:0]  t;
    r = $urandom_range(0, 9);
    if (r >= 8) return 64'd0;
    t  = (r <= 5) ? 2'b11 : (r == 6) ? 2'b10 : 2'b01;
    wa = ($urandom_range(0, 9) < 7) ? {4'h4, 6'h0, 8'($urandom)} : 18'($urandom);
    m  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    return mk(t, 8'($urandom), m, wa, $urandom);
  endfunction

  task automatic check_idle_outputs(string name);
    for (int k = 0; k < NI; k++) begin
      chk({name, "_raccout"}, k, rout[k], 64'd0);
      chk({name, "_ram"}, k, {7'd0, cs[k], we[k], addr[k], mask[k], wd[k]}, 64'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 256; i++) refmem[k][i] = 32'(i * 3);

    // Matching traffic during reset must not leak out.
    RaccIn = mk(2'b11, 8'h77, 4'h0, 18'h04001, 32'h0);
    repeat (3) @(posedge CLK);
    #1 check_idle_outputs("reset");
    @(negedge CLK);
    RaccIn = 64'd0;
    RST    = 1'b0;

    // Back-to-back reads of words 0..7 (initial contents addr*3).
    for (int i = 0; i < 8; i++) issue(mk(2'b11, 8'(i), 4'h0, 18'h04000 + 18'(i), 32'h0));
    repeat (8) issue(64'd0);

    // Write then immediate read, partial write, pass-through slots.
    issue(mk(2'b11, 8'h11, 4'hF, 18'h04000, 32'hDEADBEEF));
    issue(mk(2'b11, 8'h5A, 4'h0, 18'h04000, 32'h0));
    issue(mk(2'b11, 8'h22, 4'h3, 18'h04010, 32'h1234_5678));
    issue(mk(2'b11, 8'h23, 4'h0, 18'h04010, 32'h0));
    issue(mk(2'b11, 8'h33, 4'h0, 18'h08000, 32'hCAFE_0001));
    issue(mk(2'b10, 8'h44, 4'h0, 18'h04000, 32'hCAFE_0002));
    issue(64'd0);
    issue(mk(2'b01, 8'h55, 4'h5, 18'h04002, 32'hCAFE_0003));
    issue(mk(2'b11, 8'h66, 4'hC, 18'h3FFFF, 32'hCAFE_0004));

    for (int i = 0; i < 300; i++) issue(rand_pkt());
    repeat (8) issue(64'd0);

    // Reset with three reads in flight: nothing of them may come out.
    issue(mk(2'b11, 8'hA1, 4'h0, 18'h04001, 32'h0));
    issue(mk(2'b11, 8'hA2, 4'h0, 18'h04002, 32'h0));
    issue(mk(2'b11, 8'hA3, 4'h0, 18'h04003, 32'h0));
    #2 RST = 1'b1;
    for (int k = 0; k < NI; k++) begin
      oq[k].delete();
      rq[k].delete();
    end
    #1 check_idle_outputs("reset_midflight");
    @(negedge CLK);
    RaccIn = 64'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 100; i++) issue(rand_pkt());
    repeat (10) issue(64'd0);

    for (int k = 0; k < NI; k++) begin
      chk("leftover_out", k, 64'(oq[k].size()), 64'd0);
      chk("leftover_ram", k, 64'(rq[k].size()), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
